// File: rtl/mult_perip_pkg.sv
// rtl/mult_perip_pkg.sv - shared constants and state encoding for the multiplier peripheral
package mult_perip_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [4:0] ADDR_A      = 5'h01;
    localparam logic [4:0] ADDR_B      = 5'h02;
    localparam logic [4:0] ADDR_INIT   = 5'h04;
    localparam logic [4:0] ADDR_RESULT = 5'h08;
    localparam logic [4:0] ADDR_DONE   = 5'h10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_core.sv
// rtl/mult_core.sv - sequential shift-add unsigned multiplier, one partial product per clock (busy port under MULT_BUSY_STATUS_EN)
module mult_core
    import mult_perip_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               done
`ifdef MULT_BUSY_STATUS_EN
    ,
    output logic               busy
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [2*WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [CNT_W-1:0]   cnt;

    // Control FSM and datapath: capture operands on start, accumulate one bit per cycle, flag completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            multiplicand <= '0;
            multiplier   <= '0;
            product      <= '0;
            cnt          <= '0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        multiplicand <= {{WIDTH{1'b0}}, a};
                        multiplier   <= b;
                        product      <= '0;
                        done         <= 1'b0;
                        cnt          <= '0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (multiplier[0]) begin
                        product <= product + multiplicand;
                    end
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    cnt          <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MULT_BUSY_STATUS_EN
    // Busy covers the whole operation, including the completion cycle
    assign busy = (state != IDLE);
`endif

endmodule

// File: rtl/peripheral_mult.sv
// rtl/peripheral_mult.sv - chip-select bus wrapper around mult_core (optional busy status bit: MULT_BUSY_STATUS_EN)
module peripheral_mult
    import mult_perip_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   d_in,
    input  logic               cs,
    input  logic [4:0]         addr,
    input  logic               rd,
    input  logic               wr,
    output logic [2*WIDTH-1:0] d_out
);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               init_reg;
    logic               init_prev;
    logic               start;
    logic [2*WIDTH-1:0] product;
    logic               done;
    logic [2*WIDTH-1:0] status_word;

    // Software-visible write registers; read-only and unmapped addresses drop the write
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            init_reg <= 1'b0;
        end else if (cs && wr) begin
            case (addr)
                ADDR_A:    a_reg    <= d_in;
                ADDR_B:    b_reg    <= d_in;
                ADDR_INIT: init_reg <= d_in[0];
                default:   ;
            endcase
        end
    end

    // Previous init value so only a 0->1 transition launches an operation
    always_ff @(posedge clk) begin
        if (rst) begin
            init_prev <= 1'b0;
        end else begin
            init_prev <= init_reg;
        end
    end

    assign start = init_reg & ~init_prev;

`ifdef MULT_BUSY_STATUS_EN
    logic busy;

    mult_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_reg),
        .b       (b_reg),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    assign status_word = {{(2*WIDTH-2){1'b0}}, busy, done};
`else
    mult_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a_reg),
        .b       (b_reg),
        .product (product),
        .done    (done)
    );

    assign status_word = {{(2*WIDTH-1){1'b0}}, done};
`endif

    // Registered read mux; a same-cycle write is not yet visible here, so the read sees pre-write state
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out <= '0;
        end else if (cs && rd) begin
            case (addr)
                ADDR_RESULT: d_out <= product;
                ADDR_DONE:   d_out <= status_word;
                default:     d_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_mult.sv
// tb/tb_peripheral_mult.sv - self-checking bench for peripheral_mult against an arithmetic reference model
module tb_peripheral_mult;
    import mult_perip_pkg::*;

    localparam int W = 16;

`ifdef MULT_BUSY_STATUS_EN
    localparam logic [31:0] BUSY_READ = 32'h2;
`else
    localparam logic [31:0] BUSY_READ = 32'h0;
`endif

    logic          clk;
    logic          rst;
    logic [W-1:0]  d_in;
    logic          cs;
    logic [4:0]    addr;
    logic          rd;
    logic          wr;
    logic [2*W-1:0] d_out;

    int vectors;
    int miscompares;

    // Reference model state: what software last wrote, and the last launched product
    logic [W-1:0]   m_a;
    logic [W-1:0]   m_b;
    logic [2*W-1:0] m_prod;
    logic [31:0]    rdata;

    peripheral_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [W-1:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk);
        #1;
        d = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    // Software-level start: operands, then an init pulse; model records the expected product
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus_write(ADDR_A, a);
        bus_write(ADDR_B, b);
        m_a = a;
        m_b = b;
        bus_write(ADDR_INIT, 16'h1);
        m_prod = 32'(m_a) * 32'(m_b);
        bus_write(ADDR_INIT, 16'h0);
    endtask

    // Read done exactly W+3 clocks after the init=1 edge (already = extra cycles spent after start_op)
    task automatic finish_check(input string tag, input int already);
        idle(W + 1 - already);
        bus_read(ADDR_DONE, rdata);
        check({tag, "_done"}, rdata, 32'h1);
        bus_read(ADDR_RESULT, rdata);
        check({tag, "_result"}, rdata, m_prod);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
        idle(2);
        rst = 1'b0;
        check("reset_dout", d_out, 32'h0);
        bus_read(ADDR_DONE, rdata);
        check("reset_done", rdata, 32'h0);
        bus_read(ADDR_RESULT, rdata);
        check("reset_result", rdata, 32'h0);

        start_op(16'd5, 16'd15);
        idle(18);
        bus_read(ADDR_DONE, rdata);
        check("basic_done", rdata, 32'h1);
        bus_read(ADDR_RESULT, rdata);
        check("basic_result", rdata, 32'h0000004B);

        start_op(16'hFFFF, 16'hFFFF);
        finish_check("max", 0);
        check("max_const", m_prod, 32'hFFFE0001);

        start_op(16'h0000, 16'h1234);
        finish_check("zero", 0);

        start_op(16'd300, 16'd7);
        bus_read(ADDR_DONE, rdata);
        check("early_done", rdata, BUSY_READ);
        finish_check("restart", 1);

        for (int i = 0; i < 8; i++) begin
            start_op(16'($urandom), 16'($urandom));
            finish_check("rand", 0);
        end

        // Operand writes and a fresh init edge while running must not disturb the operation
        start_op(16'($urandom), 16'($urandom));
        idle(2);
        bus_write(ADDR_A, 16'($urandom));
        bus_write(ADDR_INIT, 16'h1);
        bus_write(ADDR_INIT, 16'h0);
        finish_check("midrun", 5);
        idle(W + 4);
        bus_read(ADDR_DONE, rdata);
        check("no_queue_done", rdata, 32'h1);
        bus_read(ADDR_RESULT, rdata);
        check("no_queue_result", rdata, m_prod);

        // Holding init high must not relaunch
        bus_write(ADDR_A, 16'd9);
        bus_write(ADDR_B, 16'd11);
        bus_write(ADDR_INIT, 16'h1);
        m_prod = 32'd99;
        idle(W + 2);
        bus_read(ADDR_RESULT, rdata);
        check("held_first", rdata, m_prod);
        bus_write(ADDR_A, 16'd3);
        bus_write(ADDR_INIT, 16'h1);
        idle(W + 2);
        bus_read(ADDR_RESULT, rdata);
        check("held_no_restart", rdata, 32'd99);
        bus_write(ADDR_INIT, 16'h0);
        m_a = 16'd3;
        m_b = 16'd11;

        // Write without chip select is ignored: A stays 3
        cs = 1'b0; wr = 1'b1; addr = ADDR_A; d_in = 16'hBEEF;
        idle(1);
        wr = 1'b0;
        bus_write(ADDR_B, 16'd1000);
        m_b = 16'd1000;
        bus_write(ADDR_INIT, 16'h1);
        m_prod = 32'(m_a) * 32'(m_b);
        bus_write(ADDR_INIT, 16'h0);
        finish_check("nocs", 0);

        // Writes to the read-only result register are dropped; simultaneous read sees the product
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = ADDR_RESULT; d_in = 16'h5555;
        idle(1);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        check("rdwr_result", d_out, m_prod);
        bus_read(ADDR_RESULT, rdata);
        check("ro_result", rdata, m_prod);
        bus_read(5'h03, rdata);
        check("unmapped", rdata, 32'h0);

        // Reset in the middle of a run aborts it
        start_op(16'd1234, 16'd4321);
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midreset_dout", d_out, 32'h0);
        bus_read(ADDR_DONE, rdata);
        check("midreset_done", rdata, 32'h0);
        bus_read(ADDR_RESULT, rdata);
        check("midreset_result", rdata, 32'h0);
        start_op(16'd1234, 16'd4321);
        finish_check("after_reset", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
